// File: rtl/bitcount_scheduler.sv
// bitcount_scheduler: round-robin arbiter in front of one shared
// shift-and-count popcount datapath. The winning requester's word is
// captured on its grant edge, shifted right one bit per cycle while the
// set bits are counted, and the count is returned tagged with the
// requester index.
//
// Handshake: a result transfers on any rising clk edge where
// result_valid && result_ready are both high; result_valid, result and
// result_id stay stable from the cycle result_valid rises until that edge,
// and result_ready may be driven freely (it has no effect on other outputs).
module bitcount_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 4,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH_A-1:0]   data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       result_valid,
  output logic [WIDTH_B-1:0]         result,
  output logic [ID_W-1:0]            result_id,
  input  logic                       result_ready,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [WIDTH_A-1:0]  a_q;
  logic [WIDTH_B-1:0]  b_q;

  logic [N_REQ-1:0]    rot;
  logic                found;
  logic [ID_W:0]       off_sel;
  logic [ID_W:0]       win_sum;
  logic [ID_W-1:0]     winner;
  logic [ID_W:0]       ptr_sum;
  logic [ID_W-1:0]     next_ptr;

  // Round-robin pick: rotate req so rr_ptr sits at bit 0, take the lowest
  // set bit, then map the offset back to an absolute requester index.
  always_comb begin
    rot     = N_REQ'({req, req} >> rr_ptr_q);
    found   = 1'b0;
    off_sel = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        found   = 1'b1;
        off_sel = (ID_W+1)'(i);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + off_sel;
    if (win_sum >= N_REQ_W) win_sum = win_sum - N_REQ_W;
    winner  = win_sum[ID_W-1:0];
    ptr_sum = {1'b0, winner} + (ID_W+1)'(1);
    if (ptr_sum == N_REQ_W) ptr_sum = '0;
    next_ptr = ptr_sum[ID_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs. gnt is held off while reset is
  // asserted so an aborted job cannot be re-granted before release.
  always_comb begin
    state_d      = state_q;
    gnt          = '0;
    busy         = (state_q != IDLE);
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && reset) begin
          gnt[winner] = 1'b1;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        if (a_q == '0) state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on grant, shift/accumulate while bits remain; A and B
  // hold in DONE so result stays stable under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            a_q      <= data[winner*WIDTH_A +: WIDTH_A];
            b_q      <= '0;
            id_q     <= winner;
            rr_ptr_q <= next_ptr;
          end
        end
        COUNT: begin
          if (a_q != '0) begin
            a_q <= a_q >> 1;
            b_q <= b_q + WIDTH_B'(a_q[0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = b_q;
  assign result_id = id_q;
  assign state_dbg = state_q;

endmodule

// File: doc/bitcount_scheduler.md
Name: bitcount_scheduler

Overview:
- Shares one shift-and-count popcount datapath between N_REQ requesters using round-robin arbitration.
- Captures the winning requester's word and sequences shift/count until the word is zero.
- Returns the count tagged with the requester ID over a valid/ready handshake.
- Sits between the per-client request logic and downstream result consumers; the datapath (shift register A, counter B, zero detect) is internal.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH_A, 8, data word width
WIDTH_B, 4, count width; integrator guarantees 2^WIDTH_B > WIDTH_A (not checked)
ID_W, $clog2(N_REQ), requester ID width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req  in  N_REQ  request per requester; level, held until granted
data  in  N_REQ*WIDTH_A  packed words; requester i occupies bits [i*WIDTH_A +: WIDTH_A]; valid while req[i]
gnt  out  N_REQ  one-hot grant pulse, one cycle; data[i] is captured at this edge
busy  out  1  high in any state other than IDLE
result_valid  out  1  count available
result  out  WIDTH_B  number of 1s in the captured word
result_id  out  ID_W  index of the requester that owns result
result_ready  in  1  consumer accepts result

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE, rr_ptr=0, A=0, B=0.
  - gnt=0, busy=0, result_valid=0, result=0, result_id=0.
  - Reset mid-operation aborts the job: no result is produced and no grant is re-issued until reset releases.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If |req: winner = first i with req[i] searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - gnt[winner]=1 combinationally this cycle.
  - At the edge: A<=data[winner], B<=0, id<=winner, rr_ptr<=(winner+1) mod N_REQ, ns=COUNT.
  - If no req, hold IDLE; gnt=0.
- COUNT:
  - If A==0: ns=DONE; A and B hold.
  - Else: A<=A>>1 (logical), B<=B+A[0] with WIDTH_B modular add, ns=COUNT.
- DONE:
  - result_valid=1; result=B and result_id=id, both stable.
  - On result_valid&&result_ready: ns=IDLE; result_valid drops the next cycle.
  - Else hold DONE indefinitely (backpressure).
- Latency, grant edge to result_valid high = k+1 cycles, where k = (index of highest set bit)+1, or k=0 for a zero word.
  - Examples: 8'hAE gives 9 cycles; 8'h00 gives 1 cycle.
- No new grant while busy. Requests arriving during COUNT/DONE wait. The earliest next grant is the cycle after the handshake, in IDLE.
- gnt is never asserted in COUNT/DONE, and is never multi-hot.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 jobs.
- req[i] dropping before grant is legal; that requester is simply skipped. req[i] values after grant are ignored.
- result and result_id are don't-care when result_valid=0 but must not glitch while it is 1.

Test Plan:
1. Reset low, then release; req=4'b0001, data[0]=8'hAE -> gnt=4'b0001 for 1 cycle; result_valid 9 cycles later with result=5, result_id=0; result_ready=1 -> returns to IDLE, busy=0.
2. req[2] only, data[2]=8'h00 -> result_valid 1 cycle after grant, result=0, result_id=2.
3. req=4'b1111 held, result_ready=1, data[i]=8'hFF -> grants in order 0,1,2,3,0; each result=8 with the matching result_id; no two gnt bits set in any cycle.
4. data[1]=8'h80, result_ready=0 for 5 cycles after result_valid -> result_valid, result=1 and result_id=1 stay stable; accepted on the first ready cycle; the next grant comes the cycle after acceptance.
5. Grant issued for data[3]=8'hF0, then reset pulsed low 3 cycles later -> all outputs 0 immediately (asynchronous); rr_ptr=0; after release, req=4'b1001 grants requester 0 first.
6. rr_ptr=2 (after serving 1), req=4'b0011 -> requester 0 granted, skipping the idle requesters 2 and 3; rr_ptr becomes 1.
